shifter_arbiter: RTL and testbench
==================================

// Module: shifter_arbiter
// PURPOSE
//  Shares one combinational 32-bit shifter (basic_shifter32) among NUM_REQ requesters
//  in the execution stage, e.g. ALU shift path and address/CSR helpers.
//  Round-robin arbitration with valid/ready handshake on each request port.
//  One registered response stage carries the result and the ID of the winning requester.
// PARAMETERS
//  NUM_REQ  2  number of requesters, legal range 1..4
//  ID_W     1  response ID width, = max(1, $clog2(NUM_REQ))
// PORTS
//  clk         in   1           single clock, rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  req_valid   in   NUM_REQ     request i valid
//  req_ready   out  NUM_REQ     request i accepted this cycle when valid&ready
//  req_op      in   2*NUM_REQ   per req: 00 SLL, 01 SRL, 10 SRA, 11 see CONFIGURATION
//  req_amount  in   5*NUM_REQ   per req shift amount 0..31
//  req_data    in   32*NUM_REQ  per req operand; req i occupies bits [32*i +: 32]
//  rsp_valid   out  1           result register holds a valid result
//  rsp_ready   in   1           consumer takes result when rsp_valid&rsp_ready
//  rsp_id      out  ID_W        index of requester that produced rsp_data
//  rsp_data    out  32          shifted result
// BEHAVIOUR
//  - Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_data=0, rr_ptr=0.
//    State=EMPTY. A result in flight is discarded, with no response after reset.
//  - States: EMPTY (no result held) and FULL (result held). can_accept = EMPTY | rsp_ready.
//  - Arbitration, combinational: search req_valid starting at index rr_ptr, ascending
//    with wrap. The first set bit wins. At most one req_ready bit is high.
//    req_ready[win] = can_accept; all other bits are 0.
//  - req_ready depends on req_valid. Requesters shall not gate req_valid on req_ready.
//  - Accept: the winning op, amount and data drive the shifter. On the clock edge,
//    rsp_data <= shifter out, rsp_id <= win, rsp_valid <= 1, state -> FULL.
//    rr_ptr <= (win+1) mod NUM_REQ.
//  - Latency: rsp_valid rises 1 cycle after acceptance.
//    Throughput is 1 result/cycle while rsp_ready=1.
//  - FULL & rsp_ready & a request valid: pop and push in the same edge.
//    The new result replaces the old one. rsp_valid stays 1.
//  - FULL & rsp_ready & no request valid: rsp_valid <= 0, state -> EMPTY.
//    rsp_data and rsp_id hold their last values.
//  - FULL & !rsp_ready: all req_ready=0. rsp_data and rsp_id are held stable.
//    rr_ptr does not change.
//  - rr_ptr advances only on an accepted handshake, never on idle or stalled cycles.
//  - Shifter control:
//    - SLL: left=1, inserted_bit=0.
//    - SRL: left=0, inserted_bit=0.
//    - SRA: left=0, inserted_bit=data[31].
//  - amount=0 returns the operand unchanged for every op.
//  - NUM_REQ=1: the arbiter degenerates to pass-through, and rsp_id is always 0.
// CONFIGURATION
//  SHIFTER_ARB_ROTATE_EN
//   defined: op 11 = ROR. result = (data >> amt) | (data << (32-amt)), built from a
//   second shifter instance. amt=0 returns data. Latency and handshake are unchanged.
//   undefined: op 11 = pass-through, result = data. No second shifter is instantiated.
// TESTING
//  1 Reset: rst_n=0 mid-FULL -> rsp_valid=0 at once, rsp_data=0. After release,
//    the first grant goes to req0.
//  2 Ops: req0 data=32'h8000_00F0 amt=4 ->
//    - SLL gives 32'h0000_0F00.
//    - SRL gives 32'h0800_000F.
//    - SRA gives 32'hF800_000F.
//    Each result arrives 1 cycle after acceptance with rsp_id=0.
//  3 Round-robin: NUM_REQ=2, both valid every cycle, rsp_ready=1 ->
//    rsp_id sequence 0,1,0,1; each port served once every 2 cycles.
//  4 Backpressure: rsp_ready=0 for 3 cycles while FULL -> req_ready=0 and
//    rsp_data stable. When rsp_ready=1 with req1 valid, the old result pops and
//    req1's result appears the next cycle.
//  5 Boundaries:
//    - amt=0 gives data unchanged.
//    - amt=31 SRA of 32'h8000_0000 gives 32'hFFFF_FFFF.
//    - amt=31 SLL of 32'h0000_0001 gives 32'h8000_0000.
//  6 Op 11, data=32'h0000_00F1 amt=4:
//    - with SHIFTER_ARB_ROTATE_EN, 32'h1000_000F.
//    - without it, 32'h0000_00F1.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit shifter among NUM_REQ requesters,
// with a single registered response stage. Define SHIFTER_ARB_ROTATE_EN to make op 11 a rotate-right.

module basic_shifter32 (
  input  logic [31:0] data,
  input  logic [4:0]  amount,
  input  logic        left,
  input  logic        inserted_bit,
  output logic [31:0] result
);
  logic [63:0] right_ext;

  always_comb begin
    right_ext = {{32{inserted_bit}}, data} >> amount;
    result    = left ? (data << amount) : right_ext[31:0];
  end
endmodule

module shifter_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [5*NUM_REQ-1:0]  req_amount,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data
);
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ALT = 2'b11} op_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  state_e          state, state_next;
  logic [ID_W-1:0] rr_ptr, win, win_next_ptr;
  logic [ID_W:0]   cand;
  logic            any_valid, can_accept, accept;
  op_e             sel_op;
  logic [4:0]      sel_amount;
  logic [31:0]     sel_data;
  logic            sh_left, sh_ins;
  logic [31:0]     sh_out, alt_result, result;

  // Search from rr_ptr upward with wrap; the first valid index wins.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!any_valid && req_valid[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        win       = cand[ID_W-1:0];
      end
    end
  end

  assign can_accept   = (state == EMPTY) || rsp_ready;
  assign accept       = any_valid && can_accept;
  assign win_next_ptr = (win == ID_W'(NUM_REQ-1)) ? '0 : win + 1'b1;

  always_comb begin
    req_ready  = '0;
    sel_op     = OP_SLL;
    sel_amount = '0;
    sel_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win) begin
        req_ready[i] = accept;
        sel_op       = op_e'(req_op[2*i +: 2]);
        sel_amount   = req_amount[5*i +: 5];
        sel_data     = req_data[32*i +: 32];
      end
    end
  end

  // Rotate reuses the main shifter as a logical right shift.
  assign sh_left = (sel_op == OP_SLL);
  assign sh_ins  = (sel_op == OP_SRA) && sel_data[31];

  basic_shifter32 u_shifter (
    .data         (sel_data),
    .amount       (sel_amount),
    .left         (sh_left),
    .inserted_bit (sh_ins),
    .result       (sh_out)
  );

`ifdef SHIFTER_ARB_ROTATE_EN
  logic [31:0] rot_hi;

  // Left by (32-amt) mod 32; amt=0 gives data, so the OR still yields data.
  basic_shifter32 u_rot_shifter (
    .data         (sel_data),
    .amount       (5'd0 - sel_amount),
    .left         (1'b1),
    .inserted_bit (1'b0),
    .result       (rot_hi)
  );
  assign alt_result = sh_out | rot_hi;
`else
  assign alt_result = sel_data;
`endif

  assign result = (sel_op == OP_ALT) ? alt_result : sh_out;

  always_comb begin
    state_next = state;
    if (accept)                          state_next = FULL;
    else if (state == FULL && rsp_ready) state_next = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      rr_ptr   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_data <= result;
        rsp_id   <= win;
        rr_ptr   <= win_next_ptr;
      end
    end
  end

  assign rsp_valid = (state == FULL);
endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter (NUM_REQ=2): behavioural model plus directed literals.
module tb_shifter_arbiter;
  localparam int N = 2;
  localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ALT = 2'b11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [2*N-1:0]  req_op;
  logic [5*N-1:0]  req_amount;
  logic [32*N-1:0] req_data;
  logic            rsp_valid, rsp_ready;
  logic [0:0]      rsp_id;
  logic [31:0]     rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  shifter_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_amount (req_amount),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [4:0] a,
                                            input logic [31:0] d);
    logic [63:0] dd;
    case (op)
      SLL:     return d << a;
      SRL:     return d >> a;
      SRA:     return $unsigned($signed(d) >>> a);
      default: begin
`ifdef SHIFTER_ARB_ROTATE_EN
        dd = {d, d} >> a;
        return dd[31:0];
`else
        dd = '0;
        return d;
`endif
      end
    endcase
  endfunction

  // Model: one result slot, a round-robin pointer, and the rule-level grant.
  logic        m_valid;
  int          m_id, m_ptr, m_win;
  logic [31:0] m_data;
  logic [1:0]  m_rdy;

  function automatic logic [1:0] exp_ready();
    int idx;
    if (m_valid && !rsp_ready) return 2'b00;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return 2'(1 << idx);
    end
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_id <= 0; m_data <= '0; m_ptr <= 0;
    end else begin
      m_rdy = exp_ready();
      if (m_rdy != 2'b00) begin
        m_win = m_rdy[1] ? 1 : 0;
        m_data  <= ref_shift(req_op[2*m_win +: 2], req_amount[5*m_win +: 5], req_data[32*m_win +: 32]);
        m_id    <= m_win;
        m_valid <= 1'b1;
        m_ptr   <= (m_win + 1) % N;
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("m_rsp_id",    32'(rsp_id),    32'(m_id));
    check("m_rsp_data",  rsp_data,       m_data);
    check("m_req_ready", 32'(req_ready), 32'(exp_ready()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [1:0] op,
                         input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_op[2*i +: 2]    = op;
    req_amount[5*i +: 5] = a;
    req_data[32*i +: 32] = d;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_op = '0; req_amount = '0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(rsp_valid), 32'd0);
    check("reset_data",  rsp_data,       32'd0);
    rst_n = 1'b1;

    // Basic ops on req0
    set_req(0, 1'b1, SLL, 5'd4, 32'h8000_00F0); tick();
    check("sll_data", rsp_data, 32'h0000_0F00);
    check("sll_id",   32'(rsp_id), 32'd0);
    check("sll_valid", 32'(rsp_valid), 32'd1);
    set_req(0, 1'b1, SRL, 5'd4, 32'h8000_00F0); tick();
    check("srl_data", rsp_data, 32'h0800_000F);
    set_req(0, 1'b1, SRA, 5'd4, 32'h8000_00F0); tick();
    check("sra_data", rsp_data, 32'hF800_000F);
    check("sra_id",   32'(rsp_id), 32'd0);

    // Boundaries
    set_req(0, 1'b1, SRA, 5'd0, 32'h8765_4321); tick();
    check("amt0_data", rsp_data, 32'h8765_4321);
    set_req(0, 1'b1, SRA, 5'd31, 32'h8000_0000); tick();
    check("sra31_data", rsp_data, 32'hFFFF_FFFF);
    set_req(0, 1'b1, SLL, 5'd31, 32'h0000_0001); tick();
    check("sll31_data", rsp_data, 32'h8000_0000);

    // Op 11
    set_req(0, 1'b1, ALT, 5'd4, 32'h0000_00F1); tick();
`ifdef SHIFTER_ARB_ROTATE_EN
    check("op11_data", rsp_data, 32'h1000_000F);
`else
    check("op11_data", rsp_data, 32'h0000_00F1);
`endif

    // Reset while FULL and stalled, pointer currently at 1
    rsp_ready = 1'b0; tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_data",  rsp_data,       32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Round-robin with both requesters always valid
    rsp_ready = 1'b1;
    set_req(0, 1'b1, SLL, 5'd1, 32'h0000_0001);
    set_req(1, 1'b1, SLL, 5'd1, 32'h0000_0002);
    #1;
    check("rr_first_ready", 32'(req_ready), 32'b01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_id",   32'(rsp_id), 32'(i % 2));
      check("rr_data", rsp_data, (i % 2 == 0) ? 32'h2 : 32'h4);
    end

    // Backpressure: result A held for 3 stalled cycles, then req1 goes through
    set_req(1, 1'b0, SLL, 5'd0, 32'h0);
    set_req(0, 1'b1, SLL, 5'd8, 32'h0000_0012); tick();
    check("bp_first", rsp_data, 32'h0000_1200);
    rsp_ready = 1'b0;
    set_req(0, 1'b0, SLL, 5'd0, 32'h0);
    set_req(1, 1'b1, SRL, 5'd4, 32'h0000_00F0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_data",  rsp_data, 32'h0000_1200);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b10);
    tick();
    check("bp_req1_id",   32'(rsp_id), 32'd1);
    check("bp_req1_data", rsp_data, 32'h0000_000F);

    // Drain: valid drops, data and id hold
    set_req(1, 1'b0, SLL, 5'd0, 32'h0);
    tick();
    check("drain_valid", 32'(rsp_valid), 32'd0);
    check("drain_data",  rsp_data, 32'h0000_000F);
    check("drain_id",    32'(rsp_id), 32'd1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
